// File: rtl/cpu_pkg.sv
// Shared encodings for the parametrised 16-bit-ISA core: opcodes, sys sub-codes,
// ALU function/condition fields and FSM state constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      OP_SYS = 2'b00,
      OP_SET = 2'b01,
      OP_MEM = 2'b10,
      OP_ALU = 2'b11
   } opcode_t;

   localparam logic [2:0] SYS_HALT = 3'd0;
   localparam logic [2:0] SYS_SETZ = 3'd1;
   localparam logic [2:0] SYS_CLRZ = 3'd2;
   localparam logic [2:0] SYS_SETC = 3'd3;
   localparam logic [2:0] SYS_CLRC = 3'd4;

   typedef enum logic [2:0] {
      FN_ADD  = 3'd0,
      FN_SUB  = 3'd1,
      FN_AND  = 3'd2,
      FN_OR   = 3'd3,
      FN_XOR  = 3'd4,
      FN_SHL1 = 3'd5,
      FN_SHR1 = 3'd6,
      FN_MOV  = 3'd7
   } alu_fn_t;

   typedef enum logic [1:0] {
      COND_ALWAYS = 2'b00,
      COND_Z      = 2'b01,
      COND_C      = 2'b10,
      COND_NZ     = 2'b11
   } alu_cond_t;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN      = 2'd0;
   localparam state_t ST_MEM_REQ  = 2'd1;
   localparam state_t ST_MEM_WAIT = 2'd2;
   localparam state_t ST_HALTED   = 2'd3;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: computes the DATA_W result, Z/C flags and whether the
// instruction's condition holds against the current flags.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_fn_t           fn,
   input  alu_cond_t         cond,
   input  logic              zIn,
   input  logic              cIn,
   output logic [DATA_W-1:0] result,
   output logic              zOut,
   output logic              cOut,
   output logic              condMet
);

   logic [DATA_W:0] wide;

   always_comb begin
      wide   = '0;
      result = '0;
      cOut   = 1'b0;
      unique case (fn)
         FN_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[DATA_W-1:0];
            cOut   = wide[DATA_W];
         end
         // Borrow shows up as the extra MSB of the widened difference.
         FN_SUB: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[DATA_W-1:0];
            cOut   = wide[DATA_W];
         end
         FN_AND:  result = a & b;
         FN_OR:   result = a | b;
         FN_XOR:  result = a ^ b;
         FN_SHL1: begin
            result = {a[DATA_W-2:0], 1'b0};
            cOut   = a[DATA_W-1];
         end
         FN_SHR1: begin
            result = {1'b0, a[DATA_W-1:1]};
            cOut   = a[0];
         end
         FN_MOV:  result = a;
      endcase
      zOut = (result == '0);
   end

   always_comb begin
      condMet = 1'b1;
      unique case (cond)
         COND_ALWAYS: condMet = 1'b1;
         COND_Z:      condMet = zIn;
         COND_C:      condMet = cIn;
         COND_NZ:     condMet = !zIn;
      endcase
   end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle core executing the 16-bit sys/set/mem/alu ISA over a DATA_W datapath,
// with a req/gnt/rvalid RAM port, resume-from-halt and a retired-instruction counter.
//  state       | meaning
//  ST_RUN      | decode romData and execute non-memory instructions in one cycle
//  ST_MEM_REQ  | RAM request outstanding, outputs held until memGnt
//  ST_MEM_WAIT | load granted, waiting for memRvalid
//  ST_HALTED   | stopped on the halt instruction until resume
module cpu_core
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       romData,
   output logic [ADDR_W-1:0] programCounter,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic              memGnt,
   input  logic              memRvalid,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              resume,
   output logic              halted,
   output logic              zeroFlag,
   output logic              carryFlag,
   output logic [31:0]       retired
);

   localparam int         PC_IDX = NUM_REGS - 1;
   localparam logic [2:0] PC_SEL = 3'(NUM_REGS - 1);

   logic [DATA_W-1:0] regs [NUM_REGS];
   state_t            state;
   state_t            nextState;
   logic [2:0]        memDst;
   logic              zFlag;
   logic              cFlag;
   logic [31:0]       retiredCnt;

   opcode_t           opcode;
   logic [2:0]        dstSel;
   logic [2:0]        aSel;
   logic [2:0]        bSel;
   logic [DATA_W-1:0] aVal;
   logic [DATA_W-1:0] bVal;
   logic [DATA_W-1:0] dstVal;

   logic [DATA_W-1:0] aluResult;
   logic              aluZ;
   logic              aluC;
   logic              condMet;

   logic              wrEn;
   logic [2:0]        wrIdx;
   logic [DATA_W-1:0] wrData;
   logic              advance;
   logic              retire;

   logic [ADDR_W-1:0] pcLow;
   logic [ADDR_W-1:0] pcInc;
   logic [ADDR_W-1:0] issueAddr;

   assign opcode = opcode_t'(romData[15:14]);
   assign dstSel = romData[13:11];
   assign aSel   = romData[10:8];
   assign bSel   = romData[7:5];

   // Register fields beyond NUM_REGS read as zero.
   always_comb begin
      aVal   = '0;
      bVal   = '0;
      dstVal = '0;
      if (int'(aSel) < NUM_REGS)   aVal   = regs[aSel];
      if (int'(bSel) < NUM_REGS)   bVal   = regs[bSel];
      if (int'(dstSel) < NUM_REGS) dstVal = regs[dstSel];
   end

   assign pcLow     = regs[PC_IDX][ADDR_W-1:0];
   assign pcInc     = pcLow + ADDR_W'(1);
   assign issueAddr = aVal[ADDR_W-1:0] + ADDR_W'(romData[6:0]);

   cpu_alu #(.DATA_W(DATA_W)) uAlu (
      .a       (aVal),
      .b       (bVal),
      .fn      (alu_fn_t'(romData[2:0])),
      .cond    (alu_cond_t'(romData[4:3])),
      .zIn     (zFlag),
      .cIn     (cFlag),
      .result  (aluResult),
      .zOut    (aluZ),
      .cOut    (aluC),
      .condMet (condMet)
   );

   always_comb begin
      nextState = state;
      wrEn      = 1'b0;
      wrIdx     = dstSel;
      wrData    = aluResult;
      advance   = 1'b0;
      retire    = 1'b0;
      unique case (state)
         ST_RUN: begin
            unique case (opcode)
               OP_SYS: begin
                  if (romData[2:0] == SYS_HALT) begin
                     nextState = ST_HALTED;
                  end else begin
                     advance = 1'b1;
                     retire  = 1'b1;
                  end
               end
               OP_SET: begin
                  wrEn    = 1'b1;
                  wrData  = DATA_W'(romData[10:0]);
                  advance = 1'b1;
                  retire  = 1'b1;
               end
               OP_ALU: begin
                  wrEn    = condMet;
                  advance = 1'b1;
                  retire  = 1'b1;
               end
               OP_MEM: nextState = ST_MEM_REQ;
            endcase
         end
         ST_MEM_REQ: begin
            if (memGnt) begin
               if (memWe) begin
                  nextState = ST_RUN;
                  advance   = 1'b1;
                  retire    = 1'b1;
               end else begin
                  nextState = ST_MEM_WAIT;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (memRvalid) begin
               nextState = ST_RUN;
               wrEn      = 1'b1;
               wrIdx     = memDst;
               wrData    = memRdata;
               advance   = 1'b1;
               retire    = 1'b1;
            end
         end
         ST_HALTED: begin
            if (resume) begin
               nextState = ST_RUN;
               advance   = 1'b1;
            end
         end
      endcase
   end

   // A write that targets the PC is a jump and suppresses the increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (wrEn && int'(wrIdx) < NUM_REGS) regs[wrIdx] <= wrData;
         if (advance && !(wrEn && wrIdx == PC_SEL)) regs[PC_IDX] <= DATA_W'(pcInc);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_RUN;
         retiredCnt <= '0;
      end else begin
         state <= nextState;
         if (retire) retiredCnt <= retiredCnt + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         zFlag <= 1'b0;
         cFlag <= 1'b0;
      end else if (state == ST_RUN) begin
         if (opcode == OP_SYS) begin
            case (romData[2:0])
               SYS_SETZ: zFlag <= 1'b1;
               SYS_CLRZ: zFlag <= 1'b0;
               SYS_SETC: cFlag <= 1'b1;
               SYS_CLRC: cFlag <= 1'b0;
               default: ;
            endcase
         end else if (opcode == OP_ALU && condMet) begin
            zFlag <= aluZ;
            cFlag <= aluC;
         end
      end
   end

   // Request fields are captured at issue so they stay stable until granted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
         memDst   <= '0;
      end else if (state == ST_RUN && opcode == OP_MEM) begin
         memReq   <= 1'b1;
         memWe    <= romData[7];
         memAddr  <= issueAddr;
         memWdata <= dstVal;
         memDst   <= dstSel;
      end else if (state == ST_MEM_REQ && memGnt) begin
         memReq <= 1'b0;
      end
   end

   assign programCounter = pcLow;
   assign halted         = (state == ST_HALTED);
   assign zeroFlag       = zFlag;
   assign carryFlag      = cFlag;
   assign retired        = retiredCnt;

endmodule

// File: tb/tb_cpu_core.sv
// Directed program run on cpu_core with a hand-driven RAM fabric; every expected
// value below is worked out by hand from the instruction encodings.
module tb_cpu_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] romData;
   logic [15:0] programCounter;
   logic        memReq;
   logic        memWe;
   logic [15:0] memAddr;
   logic [15:0] memWdata;
   logic        memGnt;
   logic        memRvalid;
   logic [15:0] memRdata;
   logic        resume;
   logic        halted;
   logic        zeroFlag;
   logic        carryFlag;
   logic [31:0] retired;

   logic [15:0] rom [256];
   int          nChecks = 0;
   int          nPass   = 0;

   always #5 clk = ~clk;

   assign romData = rom[programCounter[7:0]];

   cpu_core #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .romData        (romData),
      .programCounter (programCounter),
      .memReq         (memReq),
      .memWe          (memWe),
      .memAddr        (memAddr),
      .memWdata       (memWdata),
      .memGnt         (memGnt),
      .memRvalid      (memRvalid),
      .memRdata       (memRdata),
      .resume         (resume),
      .halted         (halted),
      .zeroFlag       (zeroFlag),
      .carryFlag      (carryFlag),
      .retired        (retired)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] iSet(input logic [2:0] d, input logic [10:0] imm);
      return {2'b01, d, imm};
   endfunction

   function automatic logic [15:0] iAlu(input logic [2:0] d, input logic [2:0] a,
                                        input logic [2:0] b, input logic [1:0] cond,
                                        input logic [2:0] fn);
      return {2'b11, d, a, b, cond, fn};
   endfunction

   function automatic logic [15:0] iMem(input logic [2:0] d, input logic [2:0] base,
                                        input logic st, input logic [6:0] off);
      return {2'b10, d, base, st, off};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[0]  = iSet(3'd1, 11'h7FF);
      rom[1]  = iSet(3'd2, 11'd1);
      rom[2]  = iAlu(3'd3, 3'd1, 3'd2, 2'b00, 3'd0);   // r3 = r1 + r2
      rom[3]  = iMem(3'd3, 3'd4, 1'b1, 7'd5);          // store r3 -> [r4+5]
      rom[4]  = iMem(3'd5, 3'd0, 1'b0, 7'h7F);         // load r5 <- [r0+7F]
      rom[5]  = iMem(3'd5, 3'd4, 1'b1, 7'd0);          // store r5 -> [r4]
      rom[6]  = 16'h0000;                              // halt
      rom[7]  = iAlu(3'd1, 3'd0, 3'd2, 2'b00, 3'd1);   // r1 = r0 - r2
      rom[8]  = iAlu(3'd6, 3'd1, 3'd2, 2'b00, 3'd0);   // r6 = r1 + r2
      rom[9]  = iAlu(3'd3, 3'd2, 3'd0, 2'b11, 3'd7);   // if !Z r3 = r2
      rom[10] = iAlu(3'd4, 3'd2, 3'd0, 2'b01, 3'd7);   // if Z r4 = r2
      rom[11] = iMem(3'd3, 3'd4, 1'b1, 7'd0);          // store r3 -> [r4]
      rom[12] = iMem(3'd1, 3'd0, 1'b1, 7'h10);         // store r1 -> [r0+10]
      rom[13] = iSet(3'd7, 11'd20);                    // jump 20
      rom[20] = iAlu(3'd1, 3'd1, 3'd0, 2'b00, 3'd5);   // r1 = r1 << 1
      rom[21] = iAlu(3'd2, 3'd2, 3'd0, 2'b00, 3'd6);   // r2 = r2 >> 1
      rom[22] = iMem(3'd5, 3'd0, 1'b0, 7'd0);          // load r5 <- [r0]

      rst = 1'b0; memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0; resume = 1'b0;
      step();
      step();
      chk("rst_pc", 32'(programCounter), 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_flags", {30'd0, zeroFlag, carryFlag}, 32'd0);
      chk("rst_req_halt", {30'd0, memReq, halted}, 32'd0);

      rst = 1'b1;
      step(); step(); step();
      chk("t1_pc", 32'(programCounter), 32'd3);
      chk("t1_retired", retired, 32'd3);
      chk("t1_flags", {30'd0, zeroFlag, carryFlag}, 32'd0);

      // store with grant in the fourth request cycle
      step();
      chk("t3_we", {31'd0, memWe}, 32'd1);
      chk("t3_data", 32'(memWdata), 32'h800);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (memReq && memAddr == 16'd5 && memWdata == 16'h800 && programCounter == 16'd3) cnt++;
         if (i == 3) memGnt = 1'b1;
         step();
      end
      memGnt = 1'b0;
      chk("t3_held_cycles", cnt, 32'd4);
      chk("t3_req_drop", {31'd0, memReq}, 32'd0);
      chk("t3_pc", 32'(programCounter), 32'd4);
      chk("t3_retired", retired, 32'd4);

      // load with rvalid five cycles after grant
      step();
      chk("t4_req", {30'd0, memReq, memWe}, 32'b10);
      chk("t4_addr", 32'(memAddr), 32'h7F);
      memGnt = 1'b1;
      step();
      memGnt = 1'b0;
      chk("t4_req_drop", {31'd0, memReq}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (programCounter == 16'd4) cnt++;
      end
      chk("t4_pc_frozen", cnt, 32'd4);
      memRvalid = 1'b1; memRdata = 16'hBEEF;
      step();
      memRvalid = 1'b0; memRdata = '0;
      chk("t4_pc", 32'(programCounter), 32'd5);
      chk("t4_retired", retired, 32'd5);
      step();
      chk("t4_loaded", 32'(memWdata), 32'hBEEF);
      chk("t4_st_addr", 32'(memAddr), 32'd0);
      memGnt = 1'b1;
      step();
      memGnt = 1'b0;
      chk("t4_pc2", 32'(programCounter), 32'd6);

      // halt and resume
      step();
      chk("t5_halted", {31'd0, halted}, 32'd1);
      chk("t5_retired", retired, 32'd6);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (programCounter == 16'd6 && halted && !memReq) cnt++;
      end
      chk("t5_hold", cnt, 32'd10);
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk("t5_pc", 32'(programCounter), 32'd7);
      chk("t5_run", {31'd0, halted}, 32'd0);
      chk("t5_retired2", retired, 32'd6);

      // flags and conditional execution
      step();
      chk("t2_sub_flags", {30'd0, zeroFlag, carryFlag}, 32'b01);
      step();
      chk("t2_add_flags", {30'd0, zeroFlag, carryFlag}, 32'b11);
      step();
      chk("t2_nz_skip_flags", {30'd0, zeroFlag, carryFlag}, 32'b11);
      chk("t2_nz_pc", 32'(programCounter), 32'd10);
      step();
      chk("t2_z_mov_flags", {30'd0, zeroFlag, carryFlag}, 32'b00);
      step();
      chk("t2_addr_r4", 32'(memAddr), 32'd1);
      chk("t2_r3_kept", 32'(memWdata), 32'h800);
      memGnt = 1'b1; step(); memGnt = 1'b0;
      step();
      chk("t2_r1", 32'(memWdata), 32'hFFFF);
      chk("t2_addr_off", 32'(memAddr), 32'h10);
      memGnt = 1'b1; step(); memGnt = 1'b0;
      step();
      chk("jump_pc", 32'(programCounter), 32'd20);
      chk("jump_retired", retired, 32'd13);
      step();
      chk("shl_flags", {30'd0, zeroFlag, carryFlag}, 32'b01);
      step();
      chk("shr_flags", {30'd0, zeroFlag, carryFlag}, 32'b11);
      chk("shr_retired", retired, 32'd15);

      // reset while a load waits for data, then late rvalid
      step();
      memGnt = 1'b1; step(); memGnt = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("t6_pc", 32'(programCounter), 32'd0);
      chk("t6_req", {31'd0, memReq}, 32'd0);
      chk("t6_retired", retired, 32'd0);
      chk("t6_flags", {30'd0, zeroFlag, carryFlag}, 32'd0);
      memRvalid = 1'b1; memRdata = 16'h1234;
      rst = 1'b1;
      step();
      memRvalid = 1'b0; memRdata = '0;
      chk("t6_late_rvalid_pc", 32'(programCounter), 32'd1);
      chk("t6_late_req", {31'd0, memReq}, 32'd0);
      step(); step(); step();
      chk("t6_r4_cleared", 32'(memAddr), 32'd5);
      chk("t6_r3_again", 32'(memWdata), 32'h800);
      chk("t6_retired2", retired, 32'd3);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
